// File: rtl/cd101_pkg.sv
// -----------------------------------------------------------------------------
// cd101_pkg
//   Shared definitions for the cd101 synth register path: default register
//   field widths, register address map, and the SPI slave FSM encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package cd101_pkg;

  // Default SPI frame field widths (address first, then data, MSB-first).
  localparam int CD_ADDR_W = 4;
  localparam int CD_DATA_W = 12;

  // Register address map of synth_top's register file.
  localparam logic [CD_ADDR_W-1:0] REG_PITCH = 4'h0;
  localparam logic [CD_ADDR_W-1:0] REG_VOL   = 4'h1;
  localparam logic [CD_ADDR_W-1:0] REG_ENV   = 4'h2;
  localparam logic [CD_ADDR_W-1:0] REG_WAVE  = 4'h3;
  localparam logic [CD_ADDR_W-1:0] REG_LFO   = 4'h4;
  localparam logic [CD_ADDR_W-1:0] REG_FILT  = 4'h5;

  // SPI slave FSM state encoding.
  typedef logic [1:0] spi_state_t;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Brings one asynchronous pin into the clk domain through a SYNC_STAGES-deep
//   flop chain, then compares the last stage against one history flop to
//   produce single-cycle rise/fall strobes.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (clears chain and history)
//   d     in   asynchronous pin
//   q     out  synchronised level (last chain stage)
//   rise  out  one-clk strobe: q went 0 -> 1
//   fall  out  one-clk strobe: q went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      hist   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
      hist   <= stages[SYNC_STAGES-1];
    end
  end

  assign q    = stages[SYNC_STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//   SPI mode-0 slave front end: oversamples SCK/MOSI/NSS in the clk domain,
//   deserialises one ADDR_W+DATA_W frame per NSS-low window and emits a
//   one-cycle register write strobe. Frames with the wrong bit count are
//   discarded and flagged with a one-cycle frame_err instead.
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   spi_clk    in   SCK, idle low, sampled on its rising edge
//   spi_mosi   in   serial data
//   spi_nss    in   chip select, active low
//   wr_valid   out  one-clk pulse: frame committed
//   wr_addr    out  address of last committed frame (held)
//   wr_data    out  data of last committed frame (held)
//   frame_err  out  one-clk pulse: frame discarded
//   busy       out  high while a frame is being shifted in
// -----------------------------------------------------------------------------
module spi_reg_slave
  import cd101_pkg::*;
#(
  parameter int ADDR_W      = CD_ADDR_W,
  parameter int DATA_W      = CD_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_nss,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  // Saturation point one past a full frame keeps overlong frames detectable.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic nss_q, nss_rise, nss_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_clk),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_mosi),
    .q    (mosi_q),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nss (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_nss),
    .q    (nss_q),
    .rise (nss_rise),
    .fall (nss_fall)
  );

  // SCK level, SCK falls and MOSI edges carry no information in mode 0.
  logic unused_edges;
  assign unused_edges = ^{sck_q, sck_fall, mosi_rise, mosi_fall};

  spi_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   sh;
  logic [CNT_W-1:0]     cnt_next;
  logic [FRAME_W-1:0]   sh_next;

  // Shift-in result for this cycle; the frame-end check uses these values so
  // an SCK rise coinciding with the NSS rise is counted before evaluation.
  always_comb begin
    cnt_next = cnt;
    sh_next  = sh;
    if (sck_rise) begin
      sh_next = {sh[FRAME_W-2:0], mosi_q};
      if (cnt != CNT_SAT) begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_WAIT_IDLE;
      cnt       <= '0;
      sh        <= '0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Only a genuine high on NSS proves no frame is in flight.
        ST_WAIT_IDLE: begin
          if (nss_q) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (nss_fall) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            sh    <= '0;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt_next;
          sh  <= sh_next;
          if (nss_rise) begin
            state <= ST_IDLE;
            if (cnt_next == CNT_FULL) begin
              wr_valid <= 1'b1;
              wr_addr  <= sh_next[FRAME_W-1 -: ADDR_W];
              wr_data  <= sh_next[DATA_W-1:0];
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_reg_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_reg_slave
//   Directed and random SPI frames; a frame-level model predicts the sequence
//   of commit / error events and the held register outputs.
// -----------------------------------------------------------------------------
module tb_spi_reg_slave;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 12;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int HALF    = 500;  // SCK half period in ns (1 MHz)

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_nss;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;
  logic              busy;

  always #10 clk = ~clk;  // 50 MHz

  spi_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_nss   (spi_nss),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    bit err;
    int addr;
    int data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  both_hi = 0;
  int  last_addr = 0;
  int  last_data = 0;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (wr_valid) begin
      e.err = 1'b0; e.addr = int'(wr_addr); e.data = int'(wr_data);
      obs_q.push_back(e);
    end
    if (frame_err) begin
      e.err = 1'b1; e.addr = 0; e.data = 0;
      obs_q.push_back(e);
    end
    if (wr_valid && frame_err) both_hi++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: a frame of exactly FRAME_W bits is a write whose
  // leading ADDR_W bits are the address; anything else is an error.
  task automatic model_frame(input int value, input int nbits);
    ev_t e;
    if (nbits == FRAME_W) begin
      e.err  = 1'b0;
      e.addr = (value / (1 << DATA_W)) % (1 << ADDR_W);
      e.data = value % (1 << DATA_W);
      last_addr = e.addr;
      last_data = e.data;
    end else begin
      e.err = 1'b1; e.addr = 0; e.data = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic nss_low();
    spi_nss = 1'b0;
    #(HALF);
  endtask

  task automatic send_bits(input int value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = value[i];
      #(HALF) spi_clk = 1'b1;
      #(HALF) spi_clk = 1'b0;
    end
  endtask

  task automatic nss_high(input int gap);
    #(HALF);
    spi_nss = 1'b1;
    #(gap);
  endtask

  task automatic frame(input int value, input int nbits, input int gap);
    nss_low();
    send_bits(value, nbits);
    nss_high(gap);
    model_frame(value, nbits);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_err%0d", tag, i), int'(obs_q[i].err), int'(exp_q[i].err));
      check($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
    check($sformatf("%s_hold_addr", tag), int'(wr_addr), last_addr);
    check($sformatf("%s_hold_data", tag), int'(wr_data), last_data);
    check($sformatf("%s_busy", tag), int'(busy), 0);
  endtask

  initial begin
    int v, n, r, gap;
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_nss  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_valid", int'(wr_valid), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single good frame
    nss_low();
    send_bits(16'h3A5C, 16);
    check("t1_busy_mid", int'(busy), 1);
    nss_high(200);
    model_frame(16'h3A5C, 16);
    settle();
    verify("t1");

    // 2: short then long frame
    frame(15'h1ABC, 15, 200);
    frame(17'h1ABCD, 17, 200);
    settle();
    verify("t2");

    // 3: back-to-back with minimum NSS-high gap (3 clk)
    frame(16'h1001, 16, 60);
    frame(16'hF0FF, 16, 200);
    settle();
    verify("t3");

    // 4: reset in the middle of a frame
    nss_low();
    send_bits(8'hAB, 8);
    rst = 1'b1;
    last_addr = 0;
    last_data = 0;
    repeat (2) @(negedge clk);
    check("t4_rst_wr_valid", int'(wr_valid), 0);
    check("t4_rst_wr_addr", int'(wr_addr), 0);
    check("t4_rst_wr_data", int'(wr_data), 0);
    check("t4_rst_frame_err", int'(frame_err), 0);
    check("t4_rst_busy", int'(busy), 0);
    rst = 1'b0;
    send_bits(8'hCD, 8);
    nss_high(200);
    check("t4_torn_busy", int'(busy), 0);
    frame(16'h2123, 16, 200);
    settle();
    verify("t4");

    // 5: SCK activity with NSS high is ignored
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom);
      #(HALF) spi_clk = 1'b1;
      #(HALF) spi_clk = 1'b0;
      check($sformatf("t5_busy%0d", i), int'(busy), 0);
    end
    settle();
    verify("t5a");
    frame(16'h0000, 16, 200);
    settle();
    verify("t5b");

    // 6: latency from NSS rise (driven mid-cycle, so next posedge is E0)
    nss_low();
    send_bits(16'h3A5C, 16);
    #(HALF);
    spi_nss = 1'b1;
    model_frame(16'h3A5C, 16);
    @(posedge clk); #1;
    check("t6_lat_e0", int'(wr_valid), 0);
    @(posedge clk); #1;
    check("t6_lat_e1", int'(wr_valid), 0);
    @(posedge clk); #1;
    check("t6_lat_e2", int'(wr_valid), 1);
    @(posedge clk); #1;
    check("t6_lat_e3", int'(wr_valid), 0);
    @(negedge clk);
    settle();
    verify("t6");

    // Random frames of random length around FRAME_W, random legal gaps
    for (int k = 0; k < 10; k++) begin
      r   = int'($urandom_range(0, 4));
      n   = (r == 0) ? FRAME_W - 1 : ((r == 4) ? FRAME_W + 1 : FRAME_W);
      v   = int'($urandom % (32'd1 << n));
      gap = 60 + 20 * int'($urandom_range(0, 7));
      frame(v, n, gap);
    end
    settle();
    verify("rand");

    check("pulse_exclusive", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
